ayatsuki_irq_ctrl: RTL
======================

// Module: ayatsuki_irq_ctrl
// PURPOSE
//  Interrupt controller in front of ayatsuki_core's irq_req_i port.
//  - Collects IRQ_NUM external sources and latches them as pending; each source is level- or edge-triggered.
//  - Masks pending sources, picks one by fixed priority and presents it one-hot to the core.
//  - Holds that source in service until end-of-interrupt (EOI).
//  - Software configures it through a small register port with the same timing as the data RAM.
// PARAMETERS
//  IRQ_NUM    8     number of sources; equals the width of `irq_bus
//  ADDR_W     4     register-port byte-address width; register offsets 0x0..0xC
// PORTS
//  clk          in   1        core clock
//  rst          in   1        asynchronous reset, active-high
//  src_i        in   IRQ_NUM  raw interrupt lines; may be asynchronous
//  irq_req_o    out  IRQ_NUM  one-hot request to the core (`irq_bus)
//  irq_ack_i    in   1        1-cycle pulse from the core: request taken, handler entered
//  irq_eoi_i    in   1        1-cycle pulse from the core: handler returned (mret)
//  reg_w_en_i   in   1        register write strobe
//  reg_r_en_i   in   1        register read strobe
//  reg_addr_i   in   ADDR_W   register byte address; bits [1:0] are ignored
//  reg_wdata_i  in   32       write data
//  reg_rdata_o  out  32       read data, valid one cycle after reg_r_en_i
// BEHAVIOUR
//  Reset: all state goes to 0 — irq_req_o, reg_rdata_o, PENDING, ENABLE and TRIGGER; FSM = IDLE.
//   With TRIGGER = 0, every source is level-triggered after reset.
//  Input path: each src_i bit passes a 2-flop synchronizer, then a rising-edge detector (previous-value flop).
//  PENDING bit set:
//   - edge mode: on a synchronized 0->1 edge; stays sticky.
//   - level mode: tracks the synchronized level while the source is not in service.
//  PENDING bit clear:
//   - register write-1-to-clear at offset 0x0.
//   - on irq_ack_i for the granted source, if it is in edge mode.
//   - a new edge in the same cycle as the clear wins: the bit stays 1.
//  Selection: eligible = PENDING & ENABLE. The lowest index wins; ties are impossible.
//  FSM IDLE:
//   - eligible != 0 -> REQ. Latch grant id G.
//   - irq_req_o = 1<<G from the next cycle on.
//  FSM REQ:
//   - Hold irq_req_o stable; no re-arbitration, even if a higher-priority source arrives.
//   - irq_ack_i -> SVC; irq_req_o drops to 0 in the same edge.
//   - If G's ENABLE or PENDING is cleared by software before the ack: -> IDLE, irq_req_o = 0 next cycle.
//  FSM SVC:
//   - G is in service; nothing is presented to the core (no nesting).
//   - irq_eoi_i, or a write of G to CLAIM: -> IDLE. Arbitration resumes the cycle after.
//   - A CLAIM write with an id != G is ignored.
//  Minimum gap: one IDLE cycle always separates the EOI from the next request.
//  Register map (32-bit, big-endian byte lanes as the core drives them):
//   0x0 PENDING  R / W1C
//   0x4 ENABLE   RW
//   0x8 TRIGGER  RW, 1 = edge
//   0xC CLAIM    R: {in-service flag at bit 31, G}; W: EOI id
//  Unused register bits read 0.
//  Write ordering: a register write takes effect at the clock edge; arbitration in that same cycle sees the old value.
//  Simultaneous events:
//   - irq_ack_i and irq_eoi_i in the same cycle are a core protocol error. Ack is honoured; EOI is dropped.
//   - irq_ack_i outside REQ is ignored; irq_eoi_i outside SVC is ignored.
//  Reads: reg_rdata_o is registered and holds its last value when reg_r_en_i = 0.
//   - An unmapped offset reads 0x0000_0000.
//   - Reading is side-effect free.
//  Reset mid-operation: asynchronous clear of all state. A request being presented vanishes immediately.
// STRUCTURE
//  Shared define.v additions:
//   - `irq_bus width and IRQ register offsets (`irq_reg_pend, `irq_reg_en, `irq_reg_trig, `irq_reg_claim).
//   - FSM state encodings `irq_st_idle, `irq_st_req, `irq_st_svc.
//  Sub-module: irq_sync_edge (2-flop synchronizer + edge detector), generated IRQ_NUM times.
//  Top level: pending/enable/trigger registers, priority encoder, 3-state FSM, read mux.
// TESTING
//  1. Reset check: drive rst high mid-run -> irq_req_o, reg_rdata_o and every register read back 0.
//  2. Edge request + EOI:
//   - Setup: ENABLE = 0x01, TRIGGER = 0x01. Pulse src_i[0] for 1 cycle.
//   - irq_req_o = 0x01 within 4 cycles and holds.
//   - irq_ack_i -> irq_req_o = 0 next cycle; PENDING reads 0; CLAIM reads 0x8000_0000.
//   - irq_eoi_i -> CLAIM reads 0.
//  3. Priority:
//   - Setup: ENABLE = 0xFF, level mode. Raise src_i = 0x28 together.
//   - irq_req_o = 0x08 first.
//   - After ack and EOI, with src_i[3] dropped -> irq_req_o = 0x20.
//  4. Mask and withdraw:
//   - Pending src 2 with ENABLE = 0 -> no request.
//   - Set ENABLE = 0x04 -> irq_req_o = 0x04.
//   - Clear ENABLE before the ack -> irq_req_o = 0 next cycle; FSM back in IDLE.
//  5. No nesting: in SVC for src 4, raise src 1 -> irq_req_o stays 0 until EOI, then becomes 0x02 after one idle cycle.
//  6. W1C race: a new edge on src 6 in the same cycle as a W1C of bit 6 -> PENDING bit 6 reads 1.

Source files
------------

// File: rtl/ayatsuki_irq_ctrl_pkg.sv
// Shared constants and types for the ayatsuki interrupt controller.
// Register offsets are word indices (byte address >> 2).
package ayatsuki_irq_ctrl_pkg;

    localparam int IRQ_NUM_DEF = 8;

    localparam int REG_PEND  = 0;
    localparam int REG_EN    = 1;
    localparam int REG_TRIG  = 2;
    localparam int REG_CLAIM = 3;

    typedef enum logic [1:0] {
        ST_IDLE = 2'd0,
        ST_REQ  = 2'd1,
        ST_SVC  = 2'd2
    } irq_st_e;

endpackage

// File: rtl/ayatsuki_irq_ctrl_sync_edge.sv
// Two-flop synchronizer for one raw interrupt line plus rising-edge detect.
// o_rise is high for one cycle after the synchronized level goes 0->1.
module ayatsuki_irq_ctrl_sync_edge (
    input  logic clk,
    input  logic rst,
    input  logic i_src,
    output logic o_level,
    output logic o_rise
);

    logic r_meta;
    logic r_sync;
    logic r_prev;

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            r_meta <= 1'b0;
            r_sync <= 1'b0;
            r_prev <= 1'b0;
        end else begin
            r_meta <= i_src;
            r_sync <= r_meta;
            r_prev <= r_sync;
        end
    end

    assign o_level = r_sync;
    assign o_rise  = r_sync & ~r_prev;

endmodule

// File: rtl/ayatsuki_irq_ctrl.sv
// Interrupt controller: pending/enable/trigger registers, fixed-priority
// grant, IDLE/REQ/SVC handshake with the core and a registered read port.
module ayatsuki_irq_ctrl
    import ayatsuki_irq_ctrl_pkg::*;
#(
    parameter int IRQ_NUM = IRQ_NUM_DEF,
    parameter int ADDR_W  = 4
) (
    input  logic               clk,
    input  logic               rst,
    input  logic [IRQ_NUM-1:0] src_i,
    output logic [IRQ_NUM-1:0] irq_req_o,
    input  logic               irq_ack_i,
    input  logic               irq_eoi_i,
    input  logic               reg_w_en_i,
    input  logic               reg_r_en_i,
    input  logic [ADDR_W-1:0]  reg_addr_i,
    input  logic [31:0]        reg_wdata_i,
    output logic [31:0]        reg_rdata_o
);

    localparam int ID_W = (IRQ_NUM > 1) ? $clog2(IRQ_NUM) : 1;

    logic [IRQ_NUM-1:0] w_level, w_rise;
    logic [IRQ_NUM-1:0] r_pend, r_en, r_trig, r_req;
    logic [IRQ_NUM-1:0] w_pend_nxt, w_req_nxt, w_elig;
    logic [IRQ_NUM-1:0] w_gnt_oh, w_w1c, w_ack_clr;
    logic [ID_W-1:0]    r_gid, w_gid_nxt, w_pick;
    irq_st_e            r_state, w_state_nxt;
    logic [ADDR_W-3:0]  w_word;
    logic               w_wr_pend, w_wr_en, w_wr_trig, w_wr_claim;
    logic               w_eoi, w_leave, w_svc_hold;
    logic [31:0]        w_rdata, r_rdata;
    logic               w_unused;

    for (genvar g = 0; g < IRQ_NUM; g++) begin : g_sync
        ayatsuki_irq_ctrl_sync_edge u_sync (
            .clk     (clk),
            .rst     (rst),
            .i_src   (src_i[g]),
            .o_level (w_level[g]),
            .o_rise  (w_rise[g])
        );
    end

    assign w_unused   = ^reg_addr_i[1:0];
    assign w_word     = reg_addr_i[ADDR_W-1:2];
    assign w_wr_pend  = reg_w_en_i && (w_word == (ADDR_W-2)'(REG_PEND));
    assign w_wr_en    = reg_w_en_i && (w_word == (ADDR_W-2)'(REG_EN));
    assign w_wr_trig  = reg_w_en_i && (w_word == (ADDR_W-2)'(REG_TRIG));
    assign w_wr_claim = reg_w_en_i && (w_word == (ADDR_W-2)'(REG_CLAIM));

    assign w_gnt_oh  = IRQ_NUM'(1) << r_gid;
    assign w_w1c     = w_wr_pend ? reg_wdata_i[IRQ_NUM-1:0] : '0;
    assign w_ack_clr = (r_state == ST_REQ && irq_ack_i) ? (w_gnt_oh & r_trig) : '0;
    // A protocol-error EOI coinciding with an ack is discarded.
    assign w_eoi     = irq_eoi_i & ~irq_ack_i;
    assign w_leave   = (r_state == ST_SVC) &&
                       (w_eoi || (w_wr_claim && reg_wdata_i == 32'(r_gid)));
    assign w_svc_hold = (r_state == ST_SVC) && !w_leave;
    assign w_elig    = r_pend & r_en;

    // Level bits freeze while in service and resume tracking on the EOI edge.
    always_comb begin
        w_pend_nxt = '0;
        for (int i = 0; i < IRQ_NUM; i++) begin
            if (r_trig[i])
                w_pend_nxt[i] = (r_pend[i] & ~w_w1c[i] & ~w_ack_clr[i]) | w_rise[i];
            else if (w_svc_hold && r_gid == ID_W'(i))
                w_pend_nxt[i] = r_pend[i] & ~w_w1c[i];
            else
                w_pend_nxt[i] = w_level[i];
        end
    end

    always_comb begin
        w_pick = '0;
        for (int i = IRQ_NUM - 1; i >= 0; i--)
            if (w_elig[i])
                w_pick = ID_W'(i);
    end

    always_comb begin
        w_state_nxt = r_state;
        w_gid_nxt   = r_gid;
        w_req_nxt   = '0;
        unique case (r_state)
            ST_IDLE: begin
                if (|w_elig) begin
                    w_state_nxt = ST_REQ;
                    w_gid_nxt   = w_pick;
                    w_req_nxt   = IRQ_NUM'(1) << w_pick;
                end
            end
            ST_REQ: begin
                w_req_nxt = r_req;
                if (irq_ack_i) begin
                    w_state_nxt = ST_SVC;
                    w_req_nxt   = '0;
                end else if (!(|(w_elig & w_gnt_oh))) begin
                    w_state_nxt = ST_IDLE;
                    w_req_nxt   = '0;
                end
            end
            ST_SVC: begin
                if (w_leave)
                    w_state_nxt = ST_IDLE;
            end
            default: w_state_nxt = ST_IDLE;
        endcase
    end

    always_comb begin
        w_rdata = '0;
        case (w_word)
            (ADDR_W-2)'(REG_PEND):  w_rdata = 32'(r_pend);
            (ADDR_W-2)'(REG_EN):    w_rdata = 32'(r_en);
            (ADDR_W-2)'(REG_TRIG):  w_rdata = 32'(r_trig);
            (ADDR_W-2)'(REG_CLAIM): w_rdata = (r_state == ST_SVC) ?
                                              {1'b1, 31'(r_gid)} : '0;
            default:                w_rdata = '0;
        endcase
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            r_state <= ST_IDLE;
            r_gid   <= '0;
            r_req   <= '0;
            r_pend  <= '0;
            r_en    <= '0;
            r_trig  <= '0;
            r_rdata <= '0;
        end else begin
            r_state <= w_state_nxt;
            r_gid   <= w_gid_nxt;
            r_req   <= w_req_nxt;
            r_pend  <= w_pend_nxt;
            if (w_wr_en)
                r_en <= reg_wdata_i[IRQ_NUM-1:0];
            if (w_wr_trig)
                r_trig <= reg_wdata_i[IRQ_NUM-1:0];
            if (reg_r_en_i)
                r_rdata <= w_rdata;
        end
    end

    assign irq_req_o   = r_req;
    assign reg_rdata_o = r_rdata;

endmodule
